// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: merges NUM_REQS commit streams onto one writeback port.
// Round-robin grant, locked to one source for the length of a multi-beat
// packet (until eop), followed by a single registered output stage with
// ready/valid backpressure.
module vx_commit_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int UUID_BITS   = 44
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS*UUID_BITS-1:0]    req_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]      req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]  req_tmask,
    input  logic [NUM_REQS*32-1:0]           req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]      req_rd,
    input  logic [NUM_REQS-1:0]              req_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]              req_eop,
    output logic [NUM_REQS-1:0]              req_ready,
    output logic                             wb_valid,
    output logic [UUID_BITS-1:0]             wb_uuid,
    output logic [NW_BITS-1:0]               wb_wid,
    output logic [NUM_THREADS-1:0]           wb_tmask,
    output logic [31:0]                      wb_PC,
    output logic [NR_BITS-1:0]               wb_rd,
    output logic                             wb_wb,
    output logic [NUM_THREADS*32-1:0]        wb_data,
    output logic                             wb_eop,
    input  logic                             wb_ready
);

    localparam int DATA_W = NUM_THREADS * 32;
    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

    // Per-source views of the flattened request buses
    logic [UUID_BITS-1:0]   uuid_arr  [NUM_REQS];
    logic [NW_BITS-1:0]     wid_arr   [NUM_REQS];
    logic [NUM_THREADS-1:0] tmask_arr [NUM_REQS];
    logic [31:0]            pc_arr    [NUM_REQS];
    logic [NR_BITS-1:0]     rd_arr    [NUM_REQS];
    logic [DATA_W-1:0]      data_arr  [NUM_REQS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
            assign uuid_arr[gi]  = req_uuid[gi*UUID_BITS +: UUID_BITS];
            assign wid_arr[gi]   = req_wid[gi*NW_BITS +: NW_BITS];
            assign tmask_arr[gi] = req_tmask[gi*NUM_THREADS +: NUM_THREADS];
            assign pc_arr[gi]    = req_PC[gi*32 +: 32];
            assign rd_arr[gi]    = req_rd[gi*NR_BITS +: NR_BITS];
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [IDX_W-1:0]    ptr_reg;
    logic                lock_reg;
    logic [IDX_W-1:0]    lock_idx_reg;
    logic [NUM_REQS-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                stall_out;
    logic                fire;
    int                  cand;

    // Pick the granted source: locked source only, else first valid from ptr
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        if (lock_reg) begin
            grant_idx = lock_idx_reg;
            grant_any = req_valid[lock_idx_reg];
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                cand = (int'(ptr_reg) + k) % NUM_REQS;
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(cand);
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign stall_out = wb_valid && !wb_ready;
    assign req_ready = stall_out ? '0 : grant;
    assign fire      = grant_any && !stall_out;

    // Arbitration state: rotate pointer after eop, lock across packet beats
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg      <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else if (fire) begin
            if (req_eop[grant_idx]) begin
                lock_reg <= 1'b0;
                ptr_reg  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end else begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= grant_idx;
            end
        end
    end

    // Output stage: reloads whenever not stalled, holds the beat while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_uuid  <= '0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_PC    <= '0;
            wb_rd    <= '0;
            wb_wb    <= 1'b0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
        end else if (!stall_out) begin
            wb_valid <= fire;
            if (fire) begin
                wb_uuid  <= uuid_arr[grant_idx];
                wb_wid   <= wid_arr[grant_idx];
                wb_tmask <= tmask_arr[grant_idx];
                wb_PC    <= pc_arr[grant_idx];
                wb_rd    <= rd_arr[grant_idx];
                wb_wb    <= req_wb[grant_idx];
                wb_data  <= data_arr[grant_idx];
                wb_eop   <= req_eop[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Randomized bench for vx_commit_arbiter with a queue-based reference model.
module tb_vx_commit_arbiter;

    localparam int N  = 4;
    localparam int NT = 4;
    localparam int DW = NT * 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N*44-1:0]    req_uuid;
    logic [N*2-1:0]     req_wid;
    logic [N*NT-1:0]    req_tmask;
    logic [N*32-1:0]    req_PC;
    logic [N*5-1:0]     req_rd;
    logic [N-1:0]       req_wb;
    logic [N*DW-1:0]    req_data;
    logic [N-1:0]       req_eop;
    logic [N-1:0]       req_ready;
    logic               wb_valid;
    logic [43:0]        wb_uuid;
    logic [1:0]         wb_wid;
    logic [NT-1:0]      wb_tmask;
    logic [31:0]        wb_PC;
    logic [4:0]         wb_rd;
    logic               wb_wb;
    logic [DW-1:0]      wb_data;
    logic               wb_eop;
    logic               wb_ready;

    vx_commit_arbiter #(
        .NUM_REQS(N), .NUM_THREADS(NT), .NW_BITS(2), .NR_BITS(5), .UUID_BITS(44)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_PC(req_PC), .req_rd(req_rd), .req_wb(req_wb),
        .req_data(req_data), .req_eop(req_eop), .req_ready(req_ready),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
        .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_wb(wb_wb), .wb_data(wb_data),
        .wb_eop(wb_eop), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [43:0]   uuid;
        logic [1:0]    wid;
        logic [NT-1:0] tmask;
        logic [31:0]   pc;
        logic [4:0]    rd;
        logic          wb;
        logic [DW-1:0] data;
        logic          eop;
    } beat_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    beat_t  src_beat [N];
    int     uuid_ctr = 1;
    int     m_ptr;
    bit     m_lock;
    int     m_lidx;
    bit     m_outv;
    beat_t  sb [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t new_beat(input int src);
        beat_t b;
        b.uuid  = {2'(src), 42'(uuid_ctr)};
        b.wid   = 2'($urandom);
        b.tmask = NT'($urandom);
        b.pc    = $urandom;
        b.rd    = 5'($urandom);
        b.wb    = 1'($urandom);
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.eop   = ($urandom_range(2) == 0);
        uuid_ctr++;
        return b;
    endfunction

    // Grant by the rules: locked -> only the locked source; otherwise rotate
    // the valid vector so the pointer is bit 0 and take the lowest set bit.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        if (m_lock) return v[m_lidx] ? N'(1 << m_lidx) : '0;
        dbl = {v, v} >> m_ptr;
        rot = dbl[N-1:0];
        for (int p = 0; p < N; p++)
            if (rot[p]) return N'(1 << ((p + m_ptr) % N));
        return '0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lidx = 0; m_outv = 0;
        sb.delete();
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            req_uuid[i*44 +: 44]  = src_beat[i].uuid;
            req_wid[i*2 +: 2]     = src_beat[i].wid;
            req_tmask[i*NT +: NT] = src_beat[i].tmask;
            req_PC[i*32 +: 32]    = src_beat[i].pc;
            req_rd[i*5 +: 5]      = src_beat[i].rd;
            req_wb[i]             = src_beat[i].wb;
            req_data[i*DW +: DW]  = src_beat[i].data;
            req_eop[i]            = src_beat[i].eop;
        end
    endtask

    task automatic drive_random(input int pv, input int pr);
        reset = 1'b1;
        for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(99) < pv);
        wb_ready = ($urandom_range(99) < pr);
        pack_inputs();
    endtask

    // Compare DUT against the model for the current cycle, then advance the model
    task automatic eval_step();
        logic [N-1:0] g;
        bit           stall;
        int           gi_src;
        beat_t        f;
        stall = m_outv && !wb_ready;
        g = model_grant(req_valid);
        check_eq("req_ready", 128'(req_ready), 128'(stall ? '0 : g));
        check_eq("wb_valid", 128'(wb_valid), 128'(m_outv));
        if (m_outv) begin
            check_eq("sb_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                f = sb[0];
                check_eq("wb_uuid", 128'(wb_uuid), 128'(f.uuid));
                check_eq("wb_ctrl", 128'({wb_wid, wb_tmask, wb_rd, wb_wb, wb_eop}),
                         128'({f.wid, f.tmask, f.rd, f.wb, f.eop}));
                check_eq("wb_PC", 128'(wb_PC), 128'(f.pc));
                check_eq("wb_data", 128'(wb_data), 128'(f.data));
                if (wb_ready) begin
                    $display("beat uuid=%0h rd=%0d eop=%0b", wb_uuid, wb_rd, wb_eop);
                    void'(sb.pop_front());
                end
            end
        end
        if (!stall) begin
            m_outv = (g != 0);
            if (g != 0) begin
                gi_src = 0;
                for (int i = 0; i < N; i++) if (g[i]) gi_src = i;
                sb.push_back(src_beat[gi_src]);
                if (src_beat[gi_src].eop) begin
                    m_lock = 0;
                    m_ptr  = (gi_src + 1) % N;
                end else begin
                    m_lock = 1;
                    m_lidx = gi_src;
                end
                src_beat[gi_src] = new_beat(gi_src);
            end
        end
    endtask

    task automatic run_cycles(input int n, input int pv, input int pr);
        for (int c = 0; c < n; c++) begin
            drive_random(pv, pr);
            #1;
            eval_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        wb_ready = 1'b1;
        for (int i = 0; i < N; i++) src_beat[i] = new_beat(i);
        pack_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_wb_valid", 128'(wb_valid), 128'(0));
        check_eq("rst_wb_uuid", 128'(wb_uuid), 128'(0));
        check_eq("rst_req_ready", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;

        run_cycles(300, 70, 100);
        run_cycles(300, 90, 50);
        run_cycles(20, 90, 0);
        run_cycles(300, 40, 80);
        run_cycles(300, 100, 100);

        // Reset while traffic and possibly a lock are in flight
        run_cycles(7, 100, 60);
        reset = 1'b0;
        req_valid = '1;
        wb_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        req_valid = '1;
        wb_ready = 1'b1;
        pack_inputs();
        #1;
        check_eq("post_rst_wb_valid", 128'(wb_valid), 128'(0));
        check_eq("post_rst_wb_data", 128'(wb_data), 128'(0));
        check_eq("post_rst_grant0", 128'(req_ready), 128'(4'b0001));
        eval_step();
        @(posedge clk);
        #1;

        run_cycles(300, 60, 70);
        // Drain everything still held in the output stage
        req_valid = '0;
        run_cycles(5, 0, 100);
        check_eq("sb_drained", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
